// File: rtl/spi_slave_if.sv
// SPI mode-0 peripheral front-end for the CSR core: oversamples sclk/cs_n/mosi on clk,
// deserialises MOSI into bytes and serialises core read data onto MISO.

module spi_sync_bit #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_bar,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst_bar) begin
        if (!rst_bar) ff <= {STAGES{RST_VAL}};
        else          ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];
endmodule

module spi_slave_if #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_TX  = {DATA_WIDTH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  rst_bar,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_rdy,
    output logic                  rx_first,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_load,
    output logic                  tx_urun
);
    localparam int              CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
    // lane order {mosi, cs_n, sclk}; cs_n idles high so reset release never fakes a select
    localparam logic [2:0]      SYNC_RST = 3'b010;

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    state_t                  state, state_nxt;
    logic [2:0]              pin_raw, pin_s;
    logic [1:0]              pin_q;
    logic                    sclk_rise, sclk_fall, cs_fall, cs_rise, mosi_bit;
    logic [CNT_W-1:0]        bit_cnt;
    logic [DATA_WIDTH-1:0]   rx_shift, tx_shift, tx_hold;
    logic                    tx_pend, bnd;
    logic                    last_bit, in_frame;

    assign pin_raw = {mosi, cs_n, sclk};

    for (genvar i = 0; i < 3; i++) begin : g_sync
        spi_sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(SYNC_RST[i])) u_sync (
            .clk(clk), .rst_bar(rst_bar), .d(pin_raw[i]), .q(pin_s[i])
        );
    end

    // Registered events; mosi is captured on the same edge so it lines up with sclk_rise.
    always_ff @(posedge clk or negedge rst_bar) begin
        if (!rst_bar) begin
            pin_q     <= 2'b10;
            sclk_rise <= 1'b0;
            sclk_fall <= 1'b0;
            cs_fall   <= 1'b0;
            cs_rise   <= 1'b0;
            mosi_bit  <= 1'b0;
        end else begin
            pin_q     <= pin_s[1:0];
            sclk_rise <=  pin_s[0] & ~pin_q[0];
            sclk_fall <= ~pin_s[0] &  pin_q[0];
            cs_fall   <= ~pin_s[1] &  pin_q[1];
            cs_rise   <=  pin_s[1] & ~pin_q[1];
            mosi_bit  <=  pin_s[2];
        end
    end

    assign last_bit = (bit_cnt == LAST_BIT);

    always_ff @(posedge clk or negedge rst_bar) begin
        if (!rst_bar) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        miso_oe   = 1'b0;
        in_frame  = 1'b0;
        case (state)
            IDLE: if (cs_fall) state_nxt = CMD;
            CMD: begin
                miso_oe  = 1'b1;
                in_frame = 1'b1;
                if (cs_rise)                    state_nxt = IDLE;
                else if (sclk_rise && last_bit) state_nxt = DATA;
            end
            DATA: begin
                miso_oe  = 1'b1;
                in_frame = 1'b1;
                if (cs_rise) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_bar) begin
        if (!rst_bar) begin
            bit_cnt  <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            rx_rdy   <= 1'b0;
            rx_first <= 1'b0;
            tx_shift <= '0;
            tx_hold  <= '0;
            tx_pend  <= 1'b0;
            bnd      <= 1'b0;
            miso     <= 1'b0;
            tx_urun  <= 1'b0;
        end else begin
            rx_rdy  <= 1'b0;
            tx_urun <= 1'b0;
            if (!in_frame) begin
                bit_cnt <= '0;
                bnd     <= 1'b0;
                miso    <= 1'b0;
                // the command byte always answers with DEFAULT_TX
                if (cs_fall) begin
                    miso     <= DEFAULT_TX[DATA_WIDTH-1];
                    tx_shift <= {DEFAULT_TX[DATA_WIDTH-2:0], 1'b0};
                end
            end else if (cs_rise) begin
                bit_cnt  <= '0;
                rx_shift <= '0;
                bnd      <= 1'b0;
                miso     <= 1'b0;
                tx_hold  <= '0;
                tx_pend  <= 1'b0;
            end else begin
                if (sclk_rise) begin
                    rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_bit};
                    bit_cnt  <= last_bit ? '0 : bit_cnt + 1'b1;
                    if (last_bit) begin
                        rx_data  <= {rx_shift[DATA_WIDTH-2:0], mosi_bit};
                        rx_rdy   <= 1'b1;
                        rx_first <= (state == CMD);
                        bnd      <= 1'b1;
                    end
                end
                if (sclk_fall) begin
                    if (bnd) begin
                        bnd <= 1'b0;
                        if (tx_pend) begin
                            miso     <= tx_hold[DATA_WIDTH-1];
                            tx_shift <= {tx_hold[DATA_WIDTH-2:0], 1'b0};
                            tx_pend  <= 1'b0;
                        end else begin
                            miso     <= DEFAULT_TX[DATA_WIDTH-1];
                            tx_shift <= {DEFAULT_TX[DATA_WIDTH-2:0], 1'b0};
                            tx_urun  <= 1'b1;
                        end
                    end else begin
                        miso     <= tx_shift[DATA_WIDTH-1];
                        tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
                    end
                end
            end
            // placed last so a load coincident with a consuming fall survives to the next boundary
            if (tx_load && !(in_frame && cs_rise)) begin
                tx_hold <= tx_data;
                tx_pend <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_spi_slave_if.sv
// Bench for spi_slave_if: an SPI master driven in clk steps, checked against a byte-level
// model of what the peripheral should receive, return on MISO and flag as underrun.

module tb_spi_slave_if;
    localparam int        W   = 8;
    localparam int        S   = 2;
    localparam logic [7:0] DEF = 8'h00;

    logic       clk = 1'b0, rst_bar = 1'b0;
    logic       sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0, tx_load = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       miso, miso_oe, rx_rdy, rx_first, tx_urun;
    logic [7:0] rx_data;

    always #5 clk = ~clk;

    spi_slave_if #(.DATA_WIDTH(W), .SYNC_STAGES(S), .DEFAULT_TX(DEF)) dut (
        .clk(clk), .rst_bar(rst_bar), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .rx_data(rx_data), .rx_rdy(rx_rdy),
        .rx_first(rx_first), .tx_data(tx_data), .tx_load(tx_load), .tx_urun(tx_urun)
    );

    int         checks = 0, failures = 0;
    int         urun_seen = 0, exp_urun = 0;
    int         H = S + 3;
    logic [8:0] rxq[$];
    logic [8:0] exp_rx;
    logic       m_pend = 1'b0;
    logic [7:0] m_hold = 8'h00, exp_tx = DEF;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Every rx_rdy must match the next byte the master finished shifting.
    always @(negedge clk) begin
        if (rst_bar) begin
            if (rx_rdy) begin
                if (rxq.size() == 0) chk("rx_extra", 32'(rx_rdy), 32'd0);
                else begin
                    exp_rx = rxq.pop_front();
                    chk("rx_data", 32'(rx_data), 32'(exp_rx[7:0]));
                    chk("rx_first", 32'(rx_first), 32'(exp_rx[8]));
                end
            end
            if (tx_urun) urun_seen++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ld_pulse(input logic [7:0] d);
        tx_data = d;
        tx_load = 1'b1;
        tick(1);
        tx_load = 1'b0;
        m_pend  = 1'b1;
        m_hold  = d;
    endtask

    task automatic cs_low();
        cs_n   = 1'b0;
        exp_tx = DEF;
        tick(H);
        chk("miso_oe_sel", 32'(miso_oe), 32'd1);
    endtask

    // Ends with sclk still high on the frame's last byte so cs_n rises before the final fall.
    task automatic send_byte(input logic [7:0] b, input bit first, input bit last,
                             input bit do_load, input logic [7:0] ld,
                             input bit coll, input logic [7:0] cd);
        logic [7:0] got;
        got = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            mosi = b[i];
            tick(H);
            got[i] = miso;
            sclk = 1'b1;
            if (i == 0) rxq.push_back({first, b});
            tick(H);
            if (i == 0 && do_load) ld_pulse(ld);
            if (!(i == 0 && last)) begin
                sclk = 1'b0;
                if (i == 0) begin
                    chk("miso_byte", 32'(got), 32'(exp_tx));
                    if (m_pend) exp_tx = m_hold;
                    else begin
                        exp_tx = DEF;
                        exp_urun++;
                    end
                    m_pend = 1'b0;
                    // lands on the same clk as the internal sclk-fall event
                    if (coll) begin
                        tick(S + 1);
                        ld_pulse(cd);
                    end
                end
            end
        end
        if (last) chk("miso_byte", 32'(got), 32'(exp_tx));
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            mosi = b[i];
            tick(H);
            sclk = 1'b1;
            tick(H);
            sclk = 1'b0;
        end
    endtask

    task automatic cs_high();
        cs_n = 1'b1;
        tick(H);
        sclk = 1'b0;
        tick(H);
        m_pend = 1'b0;
        tick(4);
        chk("urun_cnt", 32'(urun_seen), 32'(exp_urun));
        chk("miso_oe_idle", 32'(miso_oe), 32'd0);
        chk("miso_idle", 32'(miso), 32'd0);
        chk("rx_pending", 32'(rxq.size()), 32'd0);
    endtask

    initial begin
        int         n;
        logic [7:0] b;
        bit         last, dl, cl;

        tick(3);
        chk("rst_outs", {19'd0, miso, miso_oe, rx_rdy, rx_first, tx_urun, rx_data}, 32'd0);
        rst_bar = 1'b1;
        tick(4);

        // reset mid-frame, then a clean single-byte frame
        cs_low();
        send_bits(8'hA7, 3);
        rst_bar = 1'b0;
        #1;
        chk("rst_mid", {19'd0, miso, miso_oe, rx_rdy, rx_first, tx_urun, rx_data}, 32'd0);
        cs_n   = 1'b1;
        m_pend = 1'b0;
        tick(2);
        rst_bar = 1'b1;
        tick(S + 4);
        cs_low();
        send_byte(8'h85, 1, 1, 0, 8'h00, 0, 8'h00);
        cs_high();

        // write frame: nothing loaded, one underrun
        cs_low();
        send_byte(8'h43, 1, 0, 0, 8'h00, 0, 8'h00);
        send_byte(8'hA5, 0, 1, 0, 8'h00, 0, 8'h00);
        cs_high();

        // read frame: core answers right after the command byte
        cs_low();
        send_byte(8'h1B, 1, 0, 1, 8'h5C, 0, 8'h00);
        send_byte(8'h00, 0, 1, 0, 8'h00, 0, 8'h00);
        cs_high();

        // abort after 5 bits, then a fresh frame
        cs_low();
        send_bits(8'hFF, 5);
        tick(H);
        cs_n = 1'b1;
        tick(S + 4);
        chk("abort_oe", 32'(miso_oe), 32'd0);
        chk("abort_miso", 32'(miso), 32'd0);
        m_pend = 1'b0;
        tick(H);
        cs_low();
        send_byte(8'h01, 1, 1, 0, 8'h00, 0, 8'h00);
        cs_high();

        // double load: last one wins
        cs_low();
        ld_pulse(8'h11);
        send_byte(8'h80, 1, 0, 1, 8'h22, 0, 8'h00);
        send_byte(8'h00, 0, 1, 0, 8'h00, 0, 8'h00);
        cs_high();

        // load coincident with a consuming fall goes out one boundary later
        cs_low();
        send_byte(8'hC0, 1, 0, 0, 8'h00, 1, 8'h77);
        send_byte(8'h00, 0, 0, 0, 8'h00, 0, 8'h00);
        send_byte(8'h00, 0, 1, 0, 8'h00, 0, 8'h00);
        cs_high();

        // minimum-speed burst
        H = S + 3;
        cs_low();
        send_byte(8'hDE, 1, 0, 0, 8'h00, 0, 8'h00);
        send_byte(8'hAD, 0, 0, 0, 8'h00, 0, 8'h00);
        send_byte(8'hBE, 0, 0, 0, 8'h00, 0, 8'h00);
        send_byte(8'hEF, 0, 1, 0, 8'h00, 0, 8'h00);
        cs_high();

        // randomized frames
        repeat (12) begin
            H = S + 3 + int'($urandom_range(0, 3));
            n = 1 + int'($urandom_range(0, 3));
            cs_low();
            for (int k = 0; k < n; k++) begin
                b    = 8'($urandom);
                last = (k == n - 1);
                dl   = ($urandom_range(0, 1) == 1);
                cl   = !last && ($urandom_range(0, 3) == 0);
                send_byte(b, k == 0, last, dl, 8'($urandom), cl, 8'($urandom));
            end
            cs_high();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        chk("timeout", 32'd1, 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/spi_slave_if.md
# spi_slave_if

Serial front-end for the CSR core: an SPI mode-0 peripheral that deserialises MOSI bytes into the parallel command/data stream the CSR core consumes, and serialises the core's read data back onto MISO. It sits between the chip pins (sclk, cs_n, mosi, miso) and the CSR core, oversampling all SPI signals on the system clock. Each frame is one command byte {op[1:0], addr[5:0]} followed by zero or more data bytes.

## Interface

- DATA_WIDTH, 8, bits per SPI byte and parallel word width
- SYNC_STAGES, 2, synchroniser flops on sclk, cs_n, mosi (legal 2..3)
- DEFAULT_TX, 8'h00, byte shifted out when the core has supplied nothing

- clk  input  1  system clock; all logic on posedge
- rst_bar  input  1  reset, asynchronous, active-low
- sclk  input  1  SPI clock from master, asynchronous to clk
- cs_n  input  1  SPI chip select, active-low, asynchronous
- mosi  input  1  SPI data in, MSB first
- miso  output  1  SPI data out, MSB first
- miso_oe  output  1  pad output enable for miso; high while selected
- rx_data  output  DATA_WIDTH  last complete received byte
- rx_rdy  output  1  one-cycle strobe: rx_data holds a new byte
- rx_first  output  1  qualifies rx_rdy: byte is the frame's command byte
- tx_data  input  DATA_WIDTH  next byte to transmit
- tx_load  input  1  one-cycle strobe capturing tx_data into the holding register
- tx_urun  output  1  one-cycle strobe: byte boundary reached with no pending tx byte

## Operation

- All three SPI inputs pass through SYNC_STAGES flops, then one edge-detect flop; sclk rise/fall and cs_n fall/rise become single-cycle events.
- FSM states: IDLE, CMD, DATA.
  - IDLE: cs_n high. miso_oe=0, miso=0, bit counter=0. cs_n fall -> CMD.
  - CMD: receiving first byte. On 8th sclk rise -> DATA, rx_rdy with rx_first=1.
  - DATA: each further 8th sclk rise -> rx_rdy with rx_first=0; stays in DATA.
  - cs_n rise in CMD or DATA -> IDLE; partial byte discarded, no rx_rdy, tx holding register and pending flag cleared.
- Receive: on each sclk rise, rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi}; 3-bit counter increments, wraps 7->0. On wrap, rx_data <= completed byte.
- Transmit: holding register tx_hold plus pending flag. tx_load sets pending and captures tx_data; a second tx_load before consumption overwrites (last wins).
- miso changes only on cs_n fall and on sclk fall (mode 0). At cs_n fall, miso <= DEFAULT_TX[MSB] and tx_shift <= remaining DEFAULT_TX bits (the command byte always returns DEFAULT_TX).
- At the first sclk fall after a counter wrap: if pending, load tx_hold (MSB to miso, rest to tx_shift), clear pending; else load DEFAULT_TX and pulse tx_urun. Other sclk falls: miso <= tx_shift MSB, shift left.
- tx_load in the same cycle as a consuming sclk fall: the new byte is captured and pending stays set for the next boundary; the current boundary sees the old state.
- miso_oe = 1 in CMD and DATA.

## Timing

- Reset (rst_bar low, async): state IDLE, miso=0, miso_oe=0, rx_data=0, rx_rdy=0, rx_first=0, tx_urun=0, counters/shift/hold cleared, pending=0. Reset mid-frame aborts silently; the block resumes at the next cs_n fall after release.
- Input-to-event latency: SYNC_STAGES+1 clk cycles.
- rx_rdy asserts the cycle after the internal 8th-rise event, i.e. SYNC_STAGES+2 clk after the pin edge; rx_data and rx_first are stable from that cycle until the next rx_rdy.
- miso updates SYNC_STAGES+2 clk after the pin sclk fall.
- sclk high and low phases must each be >= SYNC_STAGES+3 clk periods; cs_n setup to first sclk rise >= SYNC_STAGES+3 clk.
- Core read turnaround: tx_load must arrive before the internal sclk-fall event following the rx_rdy it answers, else that byte is DEFAULT_TX and tx_urun pulses.

## Test plan

- Reset: hold rst_bar low mid-frame -> all outputs 0; after release, frame 0x85 -> one rx_rdy, rx_data=0x85, rx_first=1.
- Write frame: cs_n low, shift 0x43, 0xA5, cs_n high -> rx_rdy twice: (0x43, rx_first=1), (0xA5, rx_first=0); miso returns 0x00 on both bytes; tx_urun pulses once.
- Read frame: shift 0x1B; tx_load tx_data=0x5C within 2 clk of rx_rdy; shift dummy 0x00 -> master captures 0x00 then 0x5C; no tx_urun.
- Abort: cs_n high after 5 bits of 0xFF -> no rx_rdy, FSM IDLE, miso_oe=0; next frame 0x01 received correctly with rx_first=1.
- Double load / collision: two tx_load (0x11 then 0x22) before the boundary -> 0x22 transmitted; tx_load coincident with a consuming sclk fall -> byte sent at the following boundary.
- Minimum-speed sclk: half-period exactly SYNC_STAGES+3 clk, 4-byte burst 0xDE 0xAD 0xBE 0xEF -> all four received intact, rx_first only on 0xDE.
